hazard_ctrl: RTL and testbench

//  Pipeline sequencer for the E/W operand-forwarding datapath. Forwarding covers only the E result and the W write-back data.

---
 rtl/hazard_ctrl.sv | 166 ++++++++++++++++
 tb/tb_hazard_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard sequencer: load-use bubbles, multi-cycle stalls, bus freeze, redirect.
// Optional perf counters are built when HAZARD_PERF_EN is defined.
module hazard_ctrl #(
    parameter int REG_W      = 5,
    parameter int LU_BUBBLES = 2,
    parameter int PERF_W     = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             d_valid,
    input  logic [REG_W-1:0] d_ra1,
    input  logic [REG_W-1:0] d_ra2,
    input  logic             d_use1,
    input  logic             d_use2,
    input  logic             e_valid,
    input  logic [REG_W-1:0] e_dst,
    input  logic             e_regwrite,
    input  logic             e_memread,
    input  logic             e_multi_start,
    input  logic             e_multi_done,
    input  logic             e_redirect,
    input  logic             m_req,
    input  logic             m_ack,
    output logic             stall_f,
    output logic             stall_d,
    output logic             stall_e,
    output logic             stall_m,
    output logic             bubble_e,
    output logic             bubble_m,
    output logic             bubble_w,
    output logic             flush_d,
    output logic             busy
`ifdef HAZARD_PERF_EN
    ,
    output logic [PERF_W-1:0] perf_stall_cyc,
    output logic [PERF_W-1:0] perf_lu_events
`endif
);

    localparam int CNT_W = $clog2(LU_BUBBLES + 1);

    localparam logic [1:0] RUN     = 2'd0;
    localparam logic [1:0] LOADUSE = 2'd1;
    localparam logic [1:0] MULTI   = 2'd2;

    logic [1:0]       state;
    logic [1:0]       stateNext;
    logic [CNT_W-1:0] luCnt;
    logic [CNT_W-1:0] luCntNext;
    logic             freeze;
    logic             src1Hit;
    logic             src2Hit;
    logic             luHit;
    logic             luTake;

    assign freeze  = m_req & ~m_ack;
    assign src1Hit = d_use1 & (d_ra1 == e_dst);
    assign src2Hit = d_use2 & (d_ra2 == e_dst);
    assign luHit   = d_valid & e_valid & e_memread & e_regwrite
                   & (e_dst != '0) & (src1Hit | src2Hit);

    always_comb begin
        stall_f   = 1'b0;
        stall_d   = 1'b0;
        stall_e   = 1'b0;
        stall_m   = 1'b0;
        bubble_e  = 1'b0;
        bubble_m  = 1'b0;
        bubble_w  = 1'b0;
        flush_d   = 1'b0;
        luTake    = 1'b0;
        stateNext = state;
        luCntNext = luCnt;
        if (!reset) begin
            stateNext = RUN;
        end else if (freeze) begin
            // bus wait: hold everything up to M, drain W with a NOP
            stall_f  = 1'b1;
            stall_d  = 1'b1;
            stall_e  = 1'b1;
            stall_m  = 1'b1;
            bubble_w = 1'b1;
        end else begin
            unique case (1'b1)
                (state == RUN): begin
                    if (e_redirect) begin
                        flush_d  = 1'b1;
                        bubble_e = 1'b1;
                    end else if (e_multi_start) begin
                        stall_f   = 1'b1;
                        stall_d   = 1'b1;
                        stall_e   = 1'b1;
                        bubble_m  = 1'b1;
                        stateNext = MULTI;
                    end else if (luHit) begin
                        stall_f   = 1'b1;
                        stall_d   = 1'b1;
                        bubble_e  = 1'b1;
                        luTake    = 1'b1;
                        luCntNext = CNT_W'(LU_BUBBLES - 1);
                        stateNext = (LU_BUBBLES > 1) ? LOADUSE : RUN;
                    end
                end
                (state == LOADUSE): begin
                    stall_f   = 1'b1;
                    stall_d   = 1'b1;
                    bubble_e  = 1'b1;
                    luCntNext = luCnt - CNT_W'(1);
                    if (luCnt <= CNT_W'(1)) begin
                        stateNext = RUN;
                    end
                end
                (state == MULTI): begin
                    // done cycle lets the result advance into M
                    if (e_multi_done) begin
                        stateNext = RUN;
                    end else begin
                        stall_f  = 1'b1;
                        stall_d  = 1'b1;
                        stall_e  = 1'b1;
                        bubble_m = 1'b1;
                    end
                end
                default: begin
                    stateNext = RUN;
                    luCntNext = '0;
                end
            endcase
        end
    end

    assign busy = reset & (state != RUN);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= RUN;
            luCnt <= '0;
        end else begin
            state <= stateNext;
            luCnt <= luCntNext;
        end
    end

`ifdef HAZARD_PERF_EN
    logic [PERF_W-1:0] stallCyc;
    logic [PERF_W-1:0] luEvents;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stallCyc <= '0;
            luEvents <= '0;
        end else begin
            if (stall_f) begin
                stallCyc <= stallCyc + PERF_W'(1);
            end
            if (luTake) begin
                luEvents <= luEvents + PERF_W'(1);
            end
        end
    end

    assign perf_stall_cyc = stallCyc;
    assign perf_lu_events = luEvents;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed literal cases then random traffic vs a bubble-count model.
// Builds perf-counter checks when HAZARD_PERF_EN is defined.
module tb_hazard_ctrl;
    localparam int REG_W = 5;
    localparam int LB    = 2;
    localparam int PW    = 32;

    logic clk = 1'b0;
    logic reset;
    logic d_valid, d_use1, d_use2;
    logic [REG_W-1:0] d_ra1, d_ra2, e_dst;
    logic e_valid, e_regwrite, e_memread;
    logic e_multi_start, e_multi_done, e_redirect;
    logic m_req, m_ack;
    logic stall_f, stall_d, stall_e, stall_m;
    logic bubble_e, bubble_m, bubble_w, flush_d, busy;
`ifdef HAZARD_PERF_EN
    logic [PW-1:0] perf_stall_cyc, perf_lu_events;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.REG_W(REG_W), .LU_BUBBLES(LB), .PERF_W(PW)) dut (
        .clk(clk), .reset(reset),
        .d_valid(d_valid), .d_ra1(d_ra1), .d_ra2(d_ra2),
        .d_use1(d_use1), .d_use2(d_use2),
        .e_valid(e_valid), .e_dst(e_dst), .e_regwrite(e_regwrite),
        .e_memread(e_memread), .e_multi_start(e_multi_start),
        .e_multi_done(e_multi_done), .e_redirect(e_redirect),
        .m_req(m_req), .m_ack(m_ack),
        .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e),
        .stall_m(stall_m), .bubble_e(bubble_e), .bubble_m(bubble_m),
        .bubble_w(bubble_w), .flush_d(flush_d), .busy(busy)
`ifdef HAZARD_PERF_EN
        ,
        .perf_stall_cyc(perf_stall_cyc),
        .perf_lu_events(perf_lu_events)
`endif
    );

    // {stall_f,stall_d,stall_e,stall_m,bubble_e,bubble_m,bubble_w,flush_d,busy}
    logic [8:0] obs;
    assign obs = {stall_f, stall_d, stall_e, stall_m,
                  bubble_e, bubble_m, bubble_w, flush_d, busy};

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, req, $time);
        end
    endtask

    // Reference model: remaining load-use bubbles and a pending multi-cycle op.
    int bubblesLeft = 0;
    bit inMulti = 0;
    logic [PW-1:0] mStall = '0;
    logic [PW-1:0] mLu = '0;

    always @(negedge clk) begin
        logic [8:0] exp;
        bit frz, hit, pend;
        exp = '0;
        if (!reset) begin
            bubblesLeft = 0;
            inMulti = 0;
            mStall = '0;
            mLu = '0;
        end
`ifdef HAZARD_PERF_EN
        chk("perf_stall", perf_stall_cyc, mStall);
        chk("perf_lu", perf_lu_events, mLu);
`endif
        if (reset) begin
            frz = m_req && !m_ack;
            hit = d_valid && e_valid && e_memread && e_regwrite && e_dst != 0
                && ((d_use1 && d_ra1 == e_dst) || (d_use2 && d_ra2 == e_dst));
            pend = (bubblesLeft > 0) || inMulti;
            if (frz) begin
                exp = {8'b11110010, pend};
            end else if (inMulti) begin
                if (e_multi_done) begin
                    exp = 9'b000000001;
                    inMulti = 0;
                end else begin
                    exp = 9'b111001001;
                end
            end else if (bubblesLeft > 0) begin
                exp = 9'b110010001;
                bubblesLeft--;
            end else if (e_redirect) begin
                exp = 9'b000010010;
            end else if (e_multi_start) begin
                exp = 9'b111001000;
                inMulti = 1;
            end else if (hit) begin
                exp = 9'b110010000;
                bubblesLeft = LB - 1;
                mLu++;
            end
        end
        chk("model_strobes", {23'd0, obs}, {23'd0, exp});
        if (exp[8]) mStall++;
    end

    task automatic nxt();
        @(posedge clk);
        #1;
        reset = 1'b1;
        d_valid = 0; d_use1 = 0; d_use2 = 0;
        d_ra1 = '0; d_ra2 = '0; e_dst = '0;
        e_valid = 0; e_regwrite = 0; e_memread = 0;
        e_multi_start = 0; e_multi_done = 0; e_redirect = 0;
        m_req = 0; m_ack = 0;
    endtask

    task automatic want(input string nm, input logic [8:0] v);
        @(negedge clk);
        chk(nm, {23'd0, obs}, {23'd0, v});
    endtask

    task automatic loadHit();
        e_valid = 1; e_memread = 1; e_regwrite = 1; e_dst = 5'd5;
        d_valid = 1; d_ra1 = 5'd5; d_use1 = 1;
    endtask

    initial begin
        reset = 1'b0;
        d_valid = 0; d_use1 = 0; d_use2 = 0;
        d_ra1 = '0; d_ra2 = '0; e_dst = '0;
        e_valid = 0; e_regwrite = 0; e_memread = 0;
        e_multi_start = 0; e_multi_done = 0; e_redirect = 0;
        m_req = 0; m_ack = 0;
        @(negedge clk);
        chk("reset_out", {23'd0, obs}, 32'd0);
        @(negedge clk);

        nxt(); loadHit(); want("lu_c1", 9'b110010000);
        nxt(); d_valid = 1; d_ra1 = 5'd5; d_use1 = 1;
        want("lu_c2", 9'b110010001);
        nxt(); want("lu_resume", 9'b000000000);

        nxt(); loadHit(); e_dst = 0; d_ra1 = 0; want("x0", 9'b0);
        nxt(); loadHit(); d_use1 = 0; want("unused", 9'b0);

        nxt(); e_valid = 1; e_multi_start = 1; want("mul_c0", 9'b111001000);
        for (int i = 1; i < 5; i++) begin
            nxt(); want("mul_wait", 9'b111001001);
        end
        nxt(); e_multi_done = 1; want("mul_done", 9'b000000001);
        nxt(); want("mul_run", 9'b0);

        nxt(); loadHit(); want("frz_lu1", 9'b110010000);
        for (int i = 0; i < 3; i++) begin
            nxt(); m_req = 1; want("frz_hold", 9'b111100101);
        end
        nxt(); m_req = 1; m_ack = 1; want("frz_lu2", 9'b110010001);
        nxt(); want("frz_run", 9'b0);

        nxt(); loadHit(); e_redirect = 1; want("redir_lu", 9'b000010010);
        nxt(); want("redir_nolu", 9'b0);
        nxt(); loadHit(); e_multi_start = 1; want("mul_lu", 9'b111001000);
        nxt(); want("mul_lu_w", 9'b111001001);
        nxt(); e_multi_done = 1; want("mul_lu_d", 9'b000000001);
        nxt(); want("mul_lu_r", 9'b0);

        nxt(); e_valid = 1; e_multi_start = 1; want("rst_m0", 9'b111001000);
        nxt(); want("rst_m1", 9'b111001001);
        nxt(); reset = 0; want("rst_mid", 9'b0);
`ifdef HAZARD_PERF_EN
        chk("rst_perf", perf_stall_cyc | perf_lu_events, 32'd0);
`endif
        nxt(); want("rst_run", 9'b0);

        for (int n = 0; n < 4000; n++) begin
            nxt();
            reset = ($urandom_range(0, 249) != 0);
            d_valid = ($urandom_range(0, 4) != 0);
            d_use1 = $urandom_range(0, 1) == 1;
            d_use2 = $urandom_range(0, 1) == 1;
            d_ra1 = REG_W'($urandom_range(0, 3));
            d_ra2 = REG_W'($urandom_range(0, 3));
            e_dst = REG_W'($urandom_range(0, 3));
            e_valid = ($urandom_range(0, 4) != 0);
            e_regwrite = ($urandom_range(0, 3) != 0);
            e_memread = $urandom_range(0, 1) == 1;
            e_multi_start = ($urandom_range(0, 11) == 0);
            e_multi_done = ($urandom_range(0, 5) == 0);
            e_redirect = ($urandom_range(0, 9) == 0);
            m_req = ($urandom_range(0, 4) == 0);
            m_ack = $urandom_range(0, 1) == 1;
        end
        nxt();
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
